// File: rtl/my_pkg.sv
// Shared types and defaults for the 8088 local-bus slave models.
package my_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 1024;
  localparam int WS_WIDTH       = 4;

  // One-hot so each state decodes from a single flop.
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_ADDR   = 5'b00010,
    S_WAIT   = 5'b00100,
    S_ACCESS = 5'b01000,
    S_HOLD   = 5'b10000
  } bus_state_t;

endpackage

// File: rtl/bus_mem_slave_if.sv
// Demultiplexed 8088 local-bus control/address/data group seen by one slave.
interface bus_mem_slave_if import my_pkg::*; #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  CS;
  logic                  ALE;
  logic                  IOM;
  logic                  RD;
  logic                  WR;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  READY;
  logic                  BUS_ERR;
  logic                  data_oe;

  modport master (
    output CS, ALE, IOM, RD, WR, Address, data_in,
    input  READY, BUS_ERR, data_oe
  );

  modport slave (
    input  CS, ALE, IOM, RD, WR, Address, data_in,
    output READY, BUS_ERR, data_oe
  );

endinterface

// File: rtl/bus_wait_timer.sv
// Loadable down-counter; o_done flags the last wait cycle (count == 1).
// Load wins over decrement; the count parks at zero.
module bus_wait_timer import my_pkg::*; #(
  parameter int W = WS_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/bus_mem_slave.sv
// Windowed byte memory/IO slave: latch address on ALE hit, insert WAIT_STATES
// wait cycles (READY low), then one read or write; read data valid E+WAIT_STATES+1.
module bus_mem_slave import my_pkg::*; #(
  parameter int                    ADDR_WIDTH  = 20,
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    DEPTH       = DEF_DEPTH,
  parameter bit                    IO_SELECT   = 1'b0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  bus_mem_slave_if.slave        bus,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int                  IW       = $clog2(DEPTH);
  localparam bit                  HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [WS_WIDTH-1:0] WS_LOAD  = WS_WIDTH'(WAIT_STATES);

  bus_state_t            r_state;
  bus_state_t            w_next;
  logic [IW-1:0]         r_addr_q;
  logic                  r_dir_rd;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_oe;
  logic                  r_ready;
  logic                  r_bus_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_hit;
  logic w_strobe;
  logic w_latch;
  logic w_set_dir;
  logic w_dir_rd;
  logic w_err;
  logic w_load;
  logic w_done;
  logic w_rd_access;
  logic w_mem_we;

  assign w_hit = bus.ALE && bus.CS && (bus.IOM == IO_SELECT) &&
                 (bus.Address[ADDR_WIDTH-1:IW] == BASE_ADDR[ADDR_WIDTH-1:IW]);

  // Only the strobe matching the latched direction keeps the cycle alive.
  assign w_strobe = r_dir_rd ? !bus.RD : !bus.WR;

  bus_wait_timer #(.W(WS_WIDTH)) u_wait (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .i_load     (w_load),
    .i_load_val (WS_LOAD),
    .i_en       (r_state == S_WAIT),
    .o_done     (w_done)
  );

  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_set_dir   = 1'b0;
    w_dir_rd    = r_dir_rd;
    w_err       = 1'b0;
    w_load      = 1'b0;
    w_rd_access = 1'b0;
    w_mem_we    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_next  = S_ADDR;
          w_latch = 1'b1;
        end
      end
      S_ADDR: begin
        if (w_hit) begin
          w_latch = 1'b1;
        end else if (!bus.RD || !bus.WR) begin
          // Both strobes low is a protocol error; the read wins.
          w_set_dir = 1'b1;
          w_dir_rd  = !bus.RD;
          w_err     = !bus.RD && !bus.WR;
          if (HAS_WAIT) begin
            w_next = S_WAIT;
            w_load = 1'b1;
          end else begin
            w_next = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (!w_strobe) begin
          w_next = S_IDLE;
          w_err  = 1'b1;
        end else if (w_done) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_next      = S_HOLD;
        w_rd_access = r_dir_rd;
        w_mem_we    = !r_dir_rd;
      end
      S_HOLD: begin
        if (!w_strobe) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_addr_q  <= '0;
      r_dir_rd  <= 1'b0;
      r_rdata   <= '0;
      r_oe      <= 1'b0;
      r_ready   <= 1'b1;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ready   <= (w_next != S_WAIT);
      r_bus_err <= w_err;
      if (w_latch) begin
        r_addr_q <= bus.Address[IW-1:0];
      end
      if (w_set_dir) begin
        r_dir_rd <= w_dir_rd;
      end
      if (w_rd_access) begin
        r_rdata <= r_mem[r_addr_q];
        r_oe    <= 1'b1;
      end else if (w_next == S_IDLE) begin
        r_oe <= 1'b0;
      end
    end
  end

  // Storage has no reset so its contents survive a bus reset.
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[r_addr_q] <= bus.data_in;
    end
  end

  assign bus.READY   = r_ready;
  assign bus.BUS_ERR = r_bus_err;
  assign bus.data_oe = r_oe;
  assign data_out    = r_oe ? r_rdata : 'z;

endmodule
